// File: rtl/drive_arbiter_if.sv
// drive_arbiter_if: command-source and PWM-driver bus of the drive arbiter.
// master = command sources / environment, slave = the arbiter itself.
interface drive_arbiter_if;
    logic       tick;
    logic [2:0] req;
    logic [2:0] vld;
    logic [1:0] cmd_us;
    logic [1:0] cmd_ir;
    logic [1:0] cmd_bt;
    logic [1:0] mode;
    logic [1:0] drv_us;
    logic [1:0] drv_ir;
    logic [1:0] drv_bt;
    logic [2:0] grant;
    logic       fault;

    modport master (
        output tick, req, vld, cmd_us, cmd_ir, cmd_bt,
        input  mode, drv_us, drv_ir, drv_bt, grant, fault
    );

    modport slave (
        input  tick, req, vld, cmd_us, cmd_ir, cmd_bt,
        output mode, drv_us, drv_ir, drv_bt, grant, fault
    );
endinterface

// File: rtl/drive_arbiter.sv
// drive_arbiter: grants one of three command sources (bit0 ultrasonic,
// bit1 IR, bit2 Bluetooth) to the motor/steer PWM driver. Fixed priority
// BT > US > IR, minimum hold before US may take over from IR, a forced
// stop (DEAD) on every ownership change and a command-stream watchdog.
// Optional feature: define ARB_WATCHDOG_EN to build the watchdog and FAULT
// state; without it FAULT is tied low and VLD is ignored.
module drive_arbiter #(
    parameter int unsigned HOLD_TICKS    = 5,
    parameter int unsigned DEAD_TICKS    = 2,
    parameter int unsigned TIMEOUT_TICKS = 25
) (
    input  logic             clk,
    input  logic             rst,
    drive_arbiter_if.slave   bus
);
    localparam logic [7:0] HOLD_LIM    = 8'(HOLD_TICKS);
    localparam logic [7:0] DEAD_LIM    = 8'(DEAD_TICKS);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_TICKS);

    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_US   = 3'b001;
    localparam logic [2:0] G_IR   = 3'b010;
    localparam logic [2:0] G_BT   = 3'b100;

    localparam logic [1:0] MODE_STOP = 2'b11;
    localparam logic [1:0] CMD_STOP  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DEAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    // Highest-priority requester as a one-hot grant.
    function automatic logic [2:0] pick_owner(input logic [2:0] req);
        logic [2:0] g;
        if (req[2]) begin
            g = G_BT;
        end else if (req[0]) begin
            g = G_US;
        end else if (req[1]) begin
            g = G_IR;
        end else begin
            g = G_NONE;
        end
        return g;
    endfunction

    // Driver MODE code of a one-hot owner.
    function automatic logic [1:0] mode_of(input logic [2:0] g);
        logic [1:0] m;
        case (g)
            G_US:    m = 2'b00;
            G_IR:    m = 2'b01;
            G_BT:    m = 2'b10;
            default: m = MODE_STOP;
        endcase
        return m;
    endfunction

    // True when some source of strictly higher priority than g requests.
    function automatic logic outranks(input logic [2:0] req, input logic [2:0] g);
        logic r;
        case (g)
            G_IR:    r = req[2] | req[0];
            G_US:    r = req[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t     state_r;
    logic [2:0] grant_r;
    logic [1:0] mode_r;
    logic [1:0] drv_us_r;
    logic [1:0] drv_ir_r;
    logic [1:0] drv_bt_r;
    logic [7:0] dead_cnt_r;
    logic [7:0] hold_r;

    logic       owner_req_s;
    logic       higher_s;
    logic       preempt_s;
    logic [1:0] run_us_s;
    logic [1:0] run_ir_s;
    logic [1:0] run_bt_s;

`ifdef ARB_WATCHDOG_EN
    logic [7:0] wdog_r;
    logic       fault_r;
    logic       owner_vld_s;
    assign owner_vld_s = |(bus.vld & grant_r);
`else
    logic       unused_vld_s;
    assign unused_vld_s = ^bus.vld;
`endif

    assign owner_req_s = |(bus.req & grant_r);
    assign higher_s    = outranks(bus.req, grant_r);

    // RUN-time preemption: BT takes any other owner at once, US takes IR only after the hold.
    always_comb begin
        preempt_s = 1'b0;
        if (bus.req[2] && (grant_r != G_BT)) begin
            preempt_s = 1'b1;
        end else if (bus.req[0] && (grant_r == G_IR) && (hold_r == HOLD_LIM)) begin
            preempt_s = 1'b1;
        end else begin
            preempt_s = 1'b0;
        end
    end

    // Route only the owner's command to its driver bus; every other bus stops.
    always_comb begin
        run_us_s = CMD_STOP;
        run_ir_s = CMD_STOP;
        run_bt_s = CMD_STOP;
        case (grant_r)
            G_US:    run_us_s = bus.cmd_us;
            G_IR:    run_ir_s = bus.cmd_ir;
            G_BT:    run_bt_s = bus.cmd_bt;
            default: run_us_s = CMD_STOP;
        endcase
    end

    // Arbitration FSM with registered outputs; outputs default to "stopped" each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= G_NONE;
            mode_r     <= MODE_STOP;
            drv_us_r   <= CMD_STOP;
            drv_ir_r   <= CMD_STOP;
            drv_bt_r   <= CMD_STOP;
            dead_cnt_r <= 8'd0;
            hold_r     <= 8'd0;
`ifdef ARB_WATCHDOG_EN
            wdog_r     <= 8'd0;
            fault_r    <= 1'b0;
`endif
        end else begin
            mode_r   <= MODE_STOP;
            drv_us_r <= CMD_STOP;
            drv_ir_r <= CMD_STOP;
            drv_bt_r <= CMD_STOP;
`ifdef ARB_WATCHDOG_EN
            fault_r  <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (|bus.req) begin
                        grant_r    <= pick_owner(bus.req);
                        dead_cnt_r <= 8'd0;
                        state_r    <= ST_DEAD;
                    end else begin
                        grant_r    <= G_NONE;
                    end
                end
                ST_DEAD: begin
                    if (!owner_req_s) begin
                        grant_r <= G_NONE;
                        state_r <= ST_IDLE;
                    end else if (higher_s) begin
                        // Restarting the count keeps the full stop interval for the new owner.
                        grant_r    <= pick_owner(bus.req);
                        dead_cnt_r <= 8'd0;
                    end else if (bus.tick) begin
                        if ((dead_cnt_r + 8'd1) == DEAD_LIM) begin
                            state_r    <= ST_RUN;
                            dead_cnt_r <= 8'd0;
                            hold_r     <= 8'd0;
`ifdef ARB_WATCHDOG_EN
                            wdog_r     <= 8'd0;
`endif
                            mode_r     <= mode_of(grant_r);
                            drv_us_r   <= run_us_s;
                            drv_ir_r   <= run_ir_s;
                            drv_bt_r   <= run_bt_s;
                        end else begin
                            dead_cnt_r <= dead_cnt_r + 8'd1;
                        end
                    end else begin
                        dead_cnt_r <= dead_cnt_r;
                    end
                end
                ST_RUN: begin
                    if (!owner_req_s) begin
                        grant_r <= G_NONE;
                        state_r <= ST_IDLE;
                    end else if (preempt_s) begin
                        grant_r    <= pick_owner(bus.req);
                        dead_cnt_r <= 8'd0;
                        state_r    <= ST_DEAD;
`ifdef ARB_WATCHDOG_EN
                    end else if (wdog_r == TIMEOUT_LIM) begin
                        fault_r <= 1'b1;
                        state_r <= ST_FAULT;
`endif
                    end else begin
                        mode_r   <= mode_of(grant_r);
                        drv_us_r <= run_us_s;
                        drv_ir_r <= run_ir_s;
                        drv_bt_r <= run_bt_s;
                        if (bus.tick && (hold_r < HOLD_LIM)) begin
                            hold_r <= hold_r + 8'd1;
                        end else begin
                            hold_r <= hold_r;
                        end
`ifdef ARB_WATCHDOG_EN
                        // A refresh wins over a coincident TICK.
                        if (owner_vld_s) begin
                            wdog_r <= 8'd0;
                        end else if (bus.tick) begin
                            wdog_r <= wdog_r + 8'd1;
                        end else begin
                            wdog_r <= wdog_r;
                        end
`endif
                    end
                end
                ST_FAULT: begin
`ifdef ARB_WATCHDOG_EN
                    if (!owner_req_s) begin
                        grant_r <= G_NONE;
                        state_r <= ST_IDLE;
                    end else begin
                        fault_r <= 1'b1;
                    end
`else
                    grant_r <= G_NONE;
                    state_r <= ST_IDLE;
`endif
                end
                default: begin
                    grant_r <= G_NONE;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mode   = mode_r;
    assign bus.grant  = grant_r;
    assign bus.drv_us = drv_us_r;
    assign bus.drv_ir = drv_ir_r;
    assign bus.drv_bt = drv_bt_r;
`ifdef ARB_WATCHDOG_EN
    assign bus.fault  = fault_r;
`else
    assign bus.fault  = 1'b0;
`endif

endmodule
